// File: rtl/conv_out_writer.sv
// conv_out_writer: requantizes NUM_PE conv results per beat and writes one packed word per beat to the output BRAM.
module conv_out_writer #(
  parameter int DW = 32,
  parameter int NUM_PE = 4,
  parameter int OUT_W = 16,
  parameter int FRAC_SHIFT = 8,
  parameter int RES_PER_MAP = 196,
  parameter int NUM_GROUPS = 2,
  parameter int ADDR_W = 10,
  localparam int GW = NUM_GROUPS > 1 ? $clog2(NUM_GROUPS) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [GW-1:0]           i_group,
  input  logic                    i_en,
  input  logic [DW*NUM_PE-1:0]    i_data,
  output logic                    o_we,
  output logic [ADDR_W-1:0]       o_addr,
  output logic [OUT_W*NUM_PE-1:0] o_wdata,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_sat,
  output logic                    o_err
);
  localparam logic signed [DW-1:0] MAX_V = DW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [DW-1:0] MIN_V = ~MAX_V;
  localparam logic [GW:0] NG = (GW + 1)'(NUM_GROUPS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(RES_PER_MAP - 1);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state;
  logic [ADDR_W-1:0] base, cnt, addr1;
  logic flush_cnt, v1, clamp, acc, start_ok, err;
  logic signed [DW-1:0] s1 [NUM_PE];
  logic [OUT_W*NUM_PE-1:0] wd;
  function automatic logic signed [DW-1:0] requant(input logic signed [DW-1:0] x);
    logic signed [DW:0] e;
    e = {x[DW-1], x};
`ifdef OUT_ROUND_EN
    e = e + (DW + 1)'(1 << (FRAC_SHIFT - 1));
`endif
    e = e >>> FRAC_SHIFT;
    return e[DW-1:0];
  endfunction
  assign acc = state == RUN && i_en;
  assign start_ok = state == IDLE && i_start && {1'b0, i_group} < NG;
  assign err = (i_en && state != RUN) || (i_start && (state != IDLE || {1'b0, i_group} >= NG));
  always_comb begin
    clamp = 1'b0;
    wd = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      wd[i*OUT_W +: OUT_W] = (s1[i] > MAX_V) ? MAX_V[OUT_W-1:0] :
                             (s1[i] < MIN_V) ? MIN_V[OUT_W-1:0] : s1[i][OUT_W-1:0];
      clamp = clamp | (s1[i] > MAX_V) | (s1[i] < MIN_V);
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1 <= 1'b0;
      addr1 <= '0;
      o_we <= 1'b0;
      o_addr <= '0;
      o_wdata <= '0;
      for (int i = 0; i < NUM_PE; i++) s1[i] <= '0;
    end else begin
      v1 <= acc;
      o_we <= v1;
      if (acc) begin
        addr1 <= base + cnt;
        for (int i = 0; i < NUM_PE; i++) s1[i] <= requant(i_data[i*DW +: DW]);
      end
      if (v1) begin
        o_addr <= addr1;
        o_wdata <= wd;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      base <= '0;
      cnt <= '0;
      flush_cnt <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_sat <= 1'b0;
      o_err <= 1'b0;
    end else begin
      o_err <= start_ok ? i_en : (o_err | err);
      o_sat <= start_ok ? 1'b0 : (o_sat | (v1 & clamp));
      o_done <= 1'b0;
      case (state)
        IDLE: if (start_ok) begin
          state <= RUN;
          base <= ADDR_W'(i_group * RES_PER_MAP);
          cnt <= '0;
          o_busy <= 1'b1;
        end
        RUN: if (i_en) begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= FLUSH;
            flush_cnt <= 1'b0;
          end
        end
        FLUSH: begin
          flush_cnt <= 1'b1;
          if (flush_cnt) begin
            state <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_out_writer.sv
// tb_conv_out_writer: directed tests for conv_out_writer (requantization, addressing, timing, error flags, reset).
module tb_conv_out_writer;
    localparam int DW = 32, NP = 4, OW = 16, N = 196;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, grp = 1'b0, en = 1'b0;
    logic [DW*NP-1:0] data = '0;
    logic we, busy, done, sat, err;
    logic [9:0] addr;
    logic [OW*NP-1:0] wdata;

    logic e_start = 1'b0;
    logic [1:0] e_grp = 2'd0;
    logic e_we, e_busy, e_done, e_sat, e_err;
    logic [3:0] e_addr;
    logic [OW*NP-1:0] e_wdata;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    conv_out_writer dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_group(grp), .i_en(en), .i_data(data),
        .o_we(we), .o_addr(addr), .o_wdata(wdata), .o_busy(busy), .o_done(done), .o_sat(sat), .o_err(err)
    );

    conv_out_writer #(.NUM_GROUPS(3), .RES_PER_MAP(4), .ADDR_W(4)) e_dut (
        .i_clk(clk), .i_rst(rst), .i_start(e_start), .i_group(e_grp), .i_en(1'b0), .i_data('0),
        .o_we(e_we), .o_addr(e_addr), .o_wdata(e_wdata), .o_busy(e_busy), .o_done(e_done), .o_sat(e_sat), .o_err(e_err)
    );

    function automatic logic [DW*NP-1:0] lanes(input int b);
        logic [DW*NP-1:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) r[i*DW +: DW] = DW'((b * NP + i) << 8);
        return r;
    endfunction

    function automatic logic [OW*NP-1:0] wlanes(input int b);
        logic [OW*NP-1:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) r[i*OW +: OW] = OW'(b * NP + i);
        return r;
    endfunction

    task automatic step(input logic e, input logic [DW*NP-1:0] d, input logic s, input logic g);
        @(posedge clk);
        #1;
        en = e; data = d; start = s; grp = g;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", we); end
        checks++; if (addr !== 10'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", addr); end
        checks++; if (wdata !== '0) begin errors++; $display("FAIL reset_wdata got %h want 0", wdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %0b want 0", sat); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err); end
        checks++; if (e_err !== 1'b0) begin errors++; $display("FAIL reset_e_err got %0b want 0", e_err); end
        rst = 1'b0;
    endtask

    task automatic test_requant();
        logic [DW*NP-1:0] d;
        logic [OW-1:0] exp0;
        int k;
        d = {32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FF00, 32'd384};
`ifdef OUT_ROUND_EN
        exp0 = 16'd2;
`else
        exp0 = 16'd1;
`endif
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, d, 1'b0, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rq_busy got %0b want 1", busy); end
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL rq_early_we got %0b want 0", we); end
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (we !== 1'b1) begin errors++; $display("FAIL rq_we got %0b want 1", we); end
        checks++; if (addr !== 10'd0) begin errors++; $display("FAIL rq_addr got %0d want 0", addr); end
        checks++; if (wdata[0 +: OW] !== exp0) begin errors++; $display("FAIL rq_lane0 got %h want %h", wdata[0 +: OW], exp0); end
        checks++; if (wdata[OW +: OW] !== 16'hFFFF) begin errors++; $display("FAIL rq_lane1 got %h want ffff", wdata[OW +: OW]); end
        checks++; if (wdata[2*OW +: OW] !== 16'h7FFF) begin errors++; $display("FAIL rq_lane2 got %h want 7fff", wdata[2*OW +: OW]); end
        checks++; if (wdata[3*OW +: OW] !== 16'h8000) begin errors++; $display("FAIL rq_lane3 got %h want 8000", wdata[3*OW +: OW]); end
        checks++; if (sat !== 1'b1) begin errors++; $display("FAIL rq_sat got %0b want 1", sat); end
        for (int b = 1; b < N; b++) step(1'b1, '0, 1'b0, 1'b0);
        k = 0;
        for (int i = 1; i <= 6 && k == 0; i++) begin
            step(1'b0, '0, 1'b0, 1'b0);
            if (done) k = i;
        end
        checks++; if (k != 3) begin errors++; $display("FAIL rq_done_delay got %0d want 3", k); end
        checks++; if (sat !== 1'b1) begin errors++; $display("FAIL rq_sat_sticky got %0b want 1", sat); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rq_busy_end got %0b want 0", busy); end
    endtask

    task automatic test_stream(input logic g, input int gap);
        int last, wb;
        logic e, wexp;
        last = (N - 1) * (gap + 1);
        step(1'b0, '0, 1'b1, g);
        for (int k = 0; k <= last + 3; k++) begin
            e = (k % (gap + 1) == 0) && k <= last;
            step(e, e ? lanes(k / (gap + 1)) : '0, 1'b0, 1'b0);
            if (k == 0) begin
                checks++; if (sat !== 1'b0) begin errors++; $display("FAIL st_sat_clear got %0b want 0", sat); end
                checks++; if (err !== 1'b0) begin errors++; $display("FAIL st_err_clear got %0b want 0", err); end
            end
            checks++; if (busy !== (k <= last + 2)) begin errors++; $display("FAIL st_busy k=%0d got %0b", k, busy); end
            checks++; if (done !== (k == last + 3)) begin errors++; $display("FAIL st_done k=%0d got %0b", k, done); end
            wexp = k >= 2 && (k - 2) % (gap + 1) == 0 && k - 2 <= last;
            checks++; if (we !== wexp) begin errors++; $display("FAIL st_we k=%0d got %0b want %0b", k, we, wexp); end
            if (wexp) begin
                wb = (k - 2) / (gap + 1);
                checks++; if (addr !== 10'(g * N + wb)) begin errors++; $display("FAIL st_addr got %0d want %0d", addr, g * N + wb); end
                checks++; if (wdata !== wlanes(wb)) begin errors++; $display("FAIL st_wdata got %h want %h", wdata, wlanes(wb)); end
            end
        end
    endtask

    task automatic test_abuse();
        int k;
        step(1'b1, lanes(7), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ab_idle_err got %0b want 1", err); end
        checks++; if (we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ab_idle_state got we=%0b busy=%0b want 0", we, busy); end
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL ab_idle_we got %0b want 0", we); end
        step(1'b0, '0, 1'b1, 1'b0);
        for (int b = 0; b < 10; b++) begin
            step(1'b1, lanes(b), 1'b0, 1'b0);
            if (b == 0) begin
                checks++; if (err !== 1'b0) begin errors++; $display("FAIL ab_err_clear got %0b want 0", err); end
            end
        end
        step(1'b0, '0, 1'b1, 1'b1);
        for (int b = 10; b < N; b++) begin
            step(1'b1, lanes(b), 1'b0, 1'b0);
            if (b == 10) begin
                checks++; if (err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ab_run_start got err=%0b busy=%0b want 1 1", err, busy); end
            end
            if (b == 12) begin
                checks++; if (we !== 1'b1 || addr !== 10'd10) begin errors++; $display("FAIL ab_counter got we=%0b addr=%0d want 1 10", we, addr); end
                checks++; if (wdata !== wlanes(10)) begin errors++; $display("FAIL ab_data got %h want %h", wdata, wlanes(10)); end
            end
        end
        k = 0;
        for (int i = 1; i <= 6 && k == 0; i++) begin
            step(1'b0, '0, 1'b0, 1'b0);
            if (done) k = i;
        end
        checks++; if (k != 3) begin errors++; $display("FAIL ab_done_delay got %0d want 3", k); end
        e_start = 1'b1; e_grp = 2'd3;
        step(1'b0, '0, 1'b0, 1'b0);
        e_start = 1'b0; e_grp = 2'd0;
        checks++; if (e_err !== 1'b1) begin errors++; $display("FAIL ab_group_err got %0b want 1", e_err); end
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (e_busy !== 1'b0 || e_we !== 1'b0) begin errors++; $display("FAIL ab_group_idle got busy=%0b we=%0b want 0 0", e_busy, e_we); end
    endtask

    task automatic test_reset_mid();
        step(1'b0, '0, 1'b1, 1'b0);
        for (int b = 0; b <= 50; b++) step(1'b1, lanes(b), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (we !== 1'b1 || addr !== 10'd49) begin errors++; $display("FAIL rm_pre got we=%0b addr=%0d want 1 49", we, addr); end
        rst = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        checks++; if (we !== 1'b0 || busy !== 1'b0 || addr !== 10'd0 || wdata !== '0) begin
            errors++; $display("FAIL rm_flush got we=%0b busy=%0b addr=%0d wdata=%h want zeros", we, busy, addr, wdata);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, 1'b0);
            checks++; if (we !== 1'b0) begin errors++; $display("FAIL rm_we got %0b want 0", we); end
        end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, lanes(5), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (we !== 1'b1 || addr !== 10'd0) begin errors++; $display("FAIL rm_restart got we=%0b addr=%0d want 1 0", we, addr); end
        checks++; if (wdata !== wlanes(5)) begin errors++; $display("FAIL rm_restart_data got %h want %h", wdata, wlanes(5)); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_requant();
        test_stream(1'b1, 0);
        test_stream(1'b0, 3);
        test_abuse();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
